// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
//   MODE_*   : pattern select encodings carried on the mode port
//   seq_len  : number of steps in one full cycle of a pattern
package led_seq_pkg;

    localparam logic [1:0] MODE_CHASE    = 2'd0;
    localparam logic [1:0] MODE_BOUNCE   = 2'd1;
    localparam logic [1:0] MODE_CONVERGE = 2'd2;
    localparam logic [1:0] MODE_BLINK    = 2'd3;

    typedef logic [1:0] mode_t;

    function automatic int seq_len(input mode_t mode, input int width);
        case (mode)
            MODE_CHASE:    return width;
            MODE_BOUNCE:   return 2*width - 2;
            MODE_CONVERGE: return width - 2;
            default:       return 2;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Control/status bundle of the LED pattern sequencer.
//   en   : run enable
//   mode : pattern select
//   div  : step period minus 1, in clk cycles
//   led  : LED drive, bit WIDTH-1 = leftmost
//   tick : step strobe, a step edge follows this cycle
//   wrap : strobe with tick when step 0 of an unchanged mode is loaded
// master drives the controls, slave is the sequencer.
interface led_pattern_seq_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 25
);
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] led;
    logic             tick;
    logic             wrap;

    modport master (output en, mode, div, input  led, tick, wrap);
    modport slave  (input  en, mode, div, output led, tick, wrap);
endinterface

// File: rtl/led_tick_div.sv
// Step prescaler: asserts tick for one cycle every (div+1) enabled cycles.
//   clk, rst : clock, async active-high reset
//   en       : 0 freezes the counter and suppresses tick
//   div      : period minus 1; may change at any time
//   tick     : step strobe
module led_tick_div #(
    parameter int DIV_W = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;

    // >= rather than == so that lowering div below the running count
    // fires on the next cycle instead of waiting for the counter to wrap.
    // cnt therefore never passes div, so it cannot overflow.
    assign tick = ~rst & en & (cnt >= div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer. Each prescaler tick loads the pattern for the
// current step into the led register and advances the step counter.
// A change on mode takes effect at the next tick, restarting the new
// pattern from step 0.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of led_pattern_seq_if (en/mode/div in,
//              led/tick/wrap out)
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    led_pattern_seq_if.slave  bus
);
    localparam int SW = $clog2(2*WIDTH - 2);
    localparam int H  = WIDTH / 2;
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB = WIDTH'(1);

    mode_t            mode_q;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] led_q;
    logic             tick;
    logic             same_mode;
    logic             last_step;
    logic [SW-1:0]    step_nxt;
    logic [WIDTH-1:0] led_nxt;

    function automatic logic [WIDTH-1:0] decode(input logic [SW-1:0] s, input mode_t m);
        int si;
        int p;
        si = int'(s);
        p  = 0;
        case (m)
            MODE_CHASE:
                decode = MSB >> si;
            MODE_BOUNCE: begin
                // Second half of the cycle walks back toward the MSB.
                p = (si < WIDTH) ? si : 2*WIDTH - 2 - si;
                decode = MSB >> p;
            end
            MODE_CONVERGE: begin
                // Two lamps mirror each other from the ends to the middle.
                p = (si < H) ? si : WIDTH - 2 - si;
                decode = (MSB >> p) | (LSB << p);
            end
            default:
                decode = s[0] ? '0 : '1;
        endcase
    endfunction

    led_tick_div #(.DIV_W(DIV_W)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .div  (bus.div),
        .tick (tick)
    );

    assign same_mode = (bus.mode == mode_q);
    assign last_step = (int'(step) == seq_len(mode_q, WIDTH) - 1);

    always_comb begin
        led_nxt  = decode(step, mode_q);
        step_nxt = last_step ? '0 : step + 1'b1;
        if (!same_mode) begin
            // Switching restarts the new pattern: show step 0 now,
            // step 1 is next.
            led_nxt  = decode('0, bus.mode);
            step_nxt = SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_CHASE;
            step   <= '0;
            led_q  <= '0;
        end else if (tick) begin
            mode_q <= bus.mode;
            step   <= step_nxt;
            led_q  <= led_nxt;
        end
    end

    assign bus.led  = led_q;
    assign bus.tick = tick;
    assign bus.wrap = tick & (step == '0) & same_mode;
endmodule

// File: tb/tb_led_pattern_seq.sv
module tb_led_pattern_seq;
    localparam int W  = 8;
    localparam int DW = 25;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   chk_on = 1'b0;
    int   checks = 0;
    int   errors = 0;

    led_pattern_seq_if #(.WIDTH(W), .DIV_W(DW)) bus ();

    led_pattern_seq #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Patterns are stored as explicit lamp sequences built from their
    // visual description; the model just indexes them.
    logic [W-1:0] pat [4][2*W];
    int           plen [4];
    int           m_cnt = 0;
    int           m_idx = 0;
    int           m_mode = 0;
    logic [W-1:0] m_led = '0;

    initial begin
        logic [W-1:0] one;
        logic [W-1:0] msb;
        one = 1;
        msb = one << (W-1);
        for (int i = 0; i < W; i++) pat[0][i] = msb >> i;
        plen[0] = W;
        for (int i = 0; i < W; i++) pat[1][i] = pat[0][i];
        for (int j = 1; j <= W-2; j++) pat[1][W-1+j] = pat[0][W-1-j];
        plen[1] = 2*W-2;
        for (int k = 0; k < W/2; k++) pat[2][k] = (msb >> k) | (one << k);
        for (int j = 1; j <= W/2-2; j++) pat[2][W/2-1+j] = pat[2][W/2-1-j];
        plen[2] = W-2;
        pat[3][0] = '1;
        pat[3][1] = '0;
        plen[3] = 2;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; m_idx <= 0; m_mode <= 0; m_led <= '0;
        end else if (bus.en && m_cnt >= int'(bus.div)) begin
            m_cnt <= 0;
            if (int'(bus.mode) == m_mode) begin
                m_led <= pat[m_mode][m_idx];
                m_idx <= (m_idx + 1) % plen[m_mode];
            end else begin
                m_mode <= int'(bus.mode);
                m_led  <= pat[bus.mode][0];
                m_idx  <= 1;
            end
        end else if (bus.en) begin
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_led", bus.led, m_led);
            check("cyc_tick", bus.tick,
                  !rst && bus.en && m_cnt >= int'(bus.div));
            check("cyc_wrap", bus.wrap,
                  !rst && bus.en && m_cnt >= int'(bus.div) && m_idx == 0 && int'(bus.mode) == m_mode);
        end
    end

    // ---------------- directed helpers ----------------
    logic [W-1:0] got_led [$];
    bit           got_wrap [$];
    int           got_gap [$];

    // Capture wrap at each of the next n ticks and led right after it.
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            bit seen;
            k = 0;
            seen = 0;
            while (!seen && k < 500) begin
                @(negedge clk);
                k++;
                if (bus.tick === 1'b1) seen = 1;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL tick_timeout waited=%0d cycles without tick", k);
            end
            got_wrap.push_back(bus.wrap);
            got_gap.push_back(k);
            @(posedge clk);
            #1;
            got_led.push_back(bus.led);
        end
    endtask

    task automatic expect_seq(input string name, input logic [7:0] el[$], input bit ew[$]);
        for (int i = 0; i < el.size(); i++) begin
            check($sformatf("%s_led%0d", name, i), got_led[i], el[i]);
            check($sformatf("%s_wrap%0d", name, i), got_wrap[i], ew[i]);
        end
        got_led.delete();
        got_wrap.delete();
        got_gap.delete();
    endtask

    logic [7:0] el [$];
    bit         ew [$];

    initial begin
        bus.en = 1'b1;
        bus.mode = 2'd0;
        bus.div = DW'(2);
        #1 rst = 1'b1;
        #2;
        check("rst_led", bus.led, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_wrap", bus.wrap, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;

        // chase after reset
        collect(9);
        for (int i = 1; i < 9; i++) check("s1_gap", got_gap[i], 3);
        el = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
        ew = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
        expect_seq("chase", el, ew);

        // bounce
        bus.mode = 2'd1;
        collect(15);
        el = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
               8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        ew = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        expect_seq("bounce", el, ew);

        // converge, blink
        bus.mode = 2'd2;
        collect(7);
        el = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42, 8'h81};
        ew = '{0, 0, 0, 0, 0, 0, 1};
        expect_seq("converge", el, ew);
        bus.mode = 2'd3;
        collect(4);
        el = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        ew = '{0, 0, 1, 0};
        expect_seq("blink", el, ew);

        // div=0 and en freeze
        bus.div = '0;
        bus.mode = 2'd0;
        collect(3);
        for (int i = 0; i < 3; i++) check("div0_gap", got_gap[i], 1);
        el = '{8'h80, 8'h40, 8'h20};
        ew = '{0, 0, 0};
        expect_seq("div0", el, ew);
        bus.en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("frz_tick", bus.tick, 0);
            check("frz_led", bus.led, 8'h20);
        end
        @(posedge clk);
        #1 bus.en = 1'b1;
        collect(2);
        el = '{8'h10, 8'h08};
        ew = '{0, 0};
        expect_seq("resume", el, ew);

        // mode switch mid-pattern
        bus.mode = 2'd2;
        collect(3);
        el = '{8'h81, 8'h42, 8'h24};
        ew = '{0, 0, 0};
        expect_seq("switch", el, ew);

        // lower div under the running count
        bus.div = DW'(100);
        begin
            int k;
            k = 0;
            while (bus.tick !== 1'b1 && k < 300) begin
                @(negedge clk);
                k++;
            end
            if (bus.tick !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL div100_timeout waited=%0d cycles without tick", k);
            end
        end
        @(posedge clk);
        repeat (50) @(posedge clk);
        #1 bus.div = DW'(2);
        @(negedge clk);
        check("div_lower_tick", bus.tick, 1);

        // async reset mid-period
        @(posedge clk);
        #1 bus.mode = 2'd0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_led", bus.led, 0);
        check("async_rst_tick", bus.tick, 0);
        check("async_rst_wrap", bus.wrap, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        collect(1);
        el = '{8'h80};
        ew = '{1};
        expect_seq("post_rst", el, ew);

        // randomized run, model-checked every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            bus.en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) bus.mode = 2'($urandom);
            if ($urandom_range(0, 29) == 0) bus.div = DW'($urandom_range(0, 5));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
